// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, TXDATA/STATUS register window.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_peripheral #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wd,
  output logic [31:0] bus_rd,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLK_DIV);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  localparam logic ParityEn = 1'b1;
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  localparam logic ParityEn = 1'b0;
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // Address decode
  logic win_hit;
  logic wr_data;
  logic wr_status;

  assign win_hit   = (bus_addr[31:3] == BASE_ADDR[31:3]);
  assign wr_data   = bus_we & win_hit & ~bus_addr[2];
  assign wr_status = bus_we & win_hit & bus_addr[2];

  // FIFO state
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            full;
  logic            empty;
  logic            push_ok;
  logic            pop;
  logic [7:0]      pop_data;

  // Transmitter state
  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push on the edge it pops.
  assign push_ok  = wr_data & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (wr_data && full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_status && bus_wd[3]) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus_wd[7:0];
    end
  end

  // Transmit FSM: each line bit lasts CLK_DIV cycles counted by baud_q.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_d  = pop_data;
`ifdef UART_PARITY_EN
          parity_d = ^pop_data;
`endif
          baud_d   = '0;
          state_d  = StStart;
        end
      end

      StStart: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      StData: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

`ifdef UART_PARITY_EN
      StParity: begin
        if (baud_q == BaudLast) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif

      StStop: begin
        if (baud_q == BaudLast) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop      = 1'b1;
            shift_d  = pop_data;
`ifdef UART_PARITY_EN
            parity_d = ^pop_data;
`endif
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level is registered from the next state so tx is a clean flop output.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle) | ~empty;

  always_comb begin
    bus_rd = 32'h0;
    if (win_hit && bus_addr[2]) begin
      bus_rd = {27'b0, ParityEn, ovf_q, busy, full, empty};
    end
  end

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus_addr[1:0], bus_wd[31:8]};

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Scoreboard bench for uart_tx_peripheral: stores push expected bytes, a tx-line monitor
// decodes frames and compares them against the queue.
module tb_uart_tx_peripheral;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'h0000_0400;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] P = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] P = 32'h0;
`endif
  localparam int FRAME = NB * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = 32'h0;
  logic [31:0] bus_wd = 32'h0;
  logic [31:0] bus_rd;
  logic        tx;
  logic        busy;

  uart_tx_peripheral #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus_we  (bus_we),
    .bus_addr(bus_addr),
    .bus_wd  (bus_wd),
    .bus_rd  (bus_rd),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];
  int         start_cycles[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus_we = 1'b1;
    bus_addr = a;
    bus_wd = d;
    @(posedge clk);
    #1;
    bus_we = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    bus_addr = a;
    #1;
    check(nm, bus_rd, e);
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy !== 1'b0 && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  // Line monitor: each bit must hold for CLK_DIV negedges; a completed frame is scored.
  int         cyc_n = 0;
  logic       mon_active = 1'b0;
  int         mon_k;
  logic       mon_ref;
  logic       mon_bad;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    int phase;
    int bitn;
    logic [7:0] e;
    cyc_n++;
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_k = 0;
        mon_bad = 1'b0;
        mon_byte = 8'h0;
        start_cycles.push_back(cyc_n);
      end
    end else begin
      mon_k++;
    end
    if (mon_active && reset) begin
      phase = mon_k % CLK_DIV;
      bitn = mon_k / CLK_DIV;
      if (phase == 0) mon_ref = tx;
      else if (tx !== mon_ref) mon_bad = 1'b1;
      if (phase == CLK_DIV - 1) begin
        if (bitn == 0 && mon_ref !== 1'b0) mon_bad = 1'b1;
        if (bitn >= 1 && bitn <= 8) mon_byte[bitn-1] = mon_ref;
`ifdef UART_PARITY_EN
        if (bitn == 9 && mon_ref !== ^mon_byte) mon_bad = 1'b1;
`endif
        if (bitn == NB - 1) begin
          if (mon_ref !== 1'b1) mon_bad = 1'b1;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", {24'b0, mon_byte}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'b0, mon_byte}, {24'b0, e});
          end
          check("frame_shape", {31'b0, mon_bad}, 32'h0);
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    int cyc;
    int n0;
    logic [7:0] stim[6];

    // Reset held for three edges
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    chk_rd("rst_status", BASE + 32'd4, 32'h1 | P);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single byte: start bit one cycle after the write edge
    exp_q.push_back(8'hA5);
    store(BASE, 32'hA5);
    check("single_tx_e0", {31'b0, tx}, 32'h1);
    chk_rd("single_status", BASE + 32'd4, 32'h4 | P);
    @(posedge clk);
    #1;
    check("single_tx_e1", {31'b0, tx}, 32'h0);
    wait_idle(FRAME + 20, cyc);
    check("single_frame_len", cyc, FRAME);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back frames without idle gap
    n0 = start_cycles.size();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      store(BASE, i);
    end
    wait_idle(3 * FRAME + 20, cyc);
    check("b2b_frames", start_cycles.size(), n0 + 3);
    if (start_cycles.size() == n0 + 3) begin
      check("b2b_gap1", start_cycles[n0+1] - start_cycles[n0], FRAME);
      check("b2b_gap2", start_cycles[n0+2] - start_cycles[n0+1], FRAME);
    end
    chk_rd("b2b_status", BASE + 32'd4, 32'h1 | P);
    repeat (3) @(posedge clk);
    #1;

    // Overflow: sixth store is dropped
    stim = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(stim[i]);
      store(BASE, {24'b0, stim[i]});
    end
    chk_rd("ovf_status", BASE + 32'd4, 32'hE | P);
    store(BASE + 32'd4, 32'h8);
    chk_rd("ovf_cleared", BASE + 32'd4, 32'h6 | P);
    wait_idle(5 * FRAME + 20, cyc);
    repeat (3) @(posedge clk);
    #1;

    // Store on the STOP->START pop edge while full is accepted
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      store(BASE, 32'h20 + i);
    end
    repeat (36) @(posedge clk);
    #1;
    exp_q.push_back(8'h25);
    store(BASE, 32'h25);
    chk_rd("fullpop_status", BASE + 32'd4, 32'h6 | P);
    wait_idle(6 * FRAME + 20, cyc);
    repeat (3) @(posedge clk);
    #1;

    // Reset during data bit 3 aborts the frame and the queued byte
    store(BASE, 32'h30);
    store(BASE, 32'h31);
    repeat (17) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tx", {31'b0, tx}, 32'h1);
    chk_rd("midrst_status", BASE + 32'd4, 32'h1 | P);
    reset = 1'b1;
    n0 = start_cycles.size();
    repeat (3 * FRAME) @(posedge clk);
    #1;
    check("midrst_no_frame", start_cycles.size(), n0);
    check("midrst_busy", {31'b0, busy}, 32'h0);

    // Stores outside the register window
    store(BASE + 32'd8, 32'h55);
    store(BASE - 32'd4, 32'h66);
    chk_rd("dec_status", BASE + 32'd4, 32'h1 | P);
    chk_rd("dec_rd_p8", BASE + 32'd8, 32'h0);
    chk_rd("dec_rd_m4", BASE - 32'd4, 32'h0);
    chk_rd("dec_rd_txdata", BASE, 32'h0);
    repeat (2 * FRAME) @(posedge clk);
    #1;
    check("dec_no_frame", start_cycles.size(), n0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
